// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/mul-div stall and branch/jump flush control with stall/flush statistics
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             id_md_start,
  input  logic             id_md_use,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             pc_ld,
  output logic             ifid_ld,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             lu_haz, md_haz, stall, redirect, launch;
  always_comb begin
    lu_haz      = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    md_haz      = (state_q == MD_WAIT) & id_md_use;
    stall       = lu_haz | md_haz;
    redirect    = ~stall & (branch_taken | jump);
    launch      = (state_q == RUN) & id_md_start & ~lu_haz;
    pc_ld       = ~rst & ~stall;
    ifid_ld     = ~rst & ~stall;
    ifid_flush  = ~rst & redirect;
    idex_bubble = rst | stall;
    md_busy     = state_q == MD_WAIT;
    state_d     = (state_q == RUN) ? (launch ? MD_WAIT : RUN) : ((cnt_q == 4'd0) ? RUN : MD_WAIT);
    cnt_d       = launch ? 4'(MD_LATENCY - 1) : ((state_q == MD_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q);
    stall_d     = (stall & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    flush_d     = (redirect & ~&flush_q) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall/flush control, mul/div tracking and counter saturation
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 0, ex_memread = 0, id_md_start = 0, id_md_use = 0, branch_taken = 0, jump = 0;
  logic pc0, ld0, fl0, bb0, busy0, pc1, ld1, fl1, bb1, busy1;
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_ctrl d0 (.clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_md_start(id_md_start), .id_md_use(id_md_use),
    .branch_taken(branch_taken), .jump(jump), .pc_ld(pc0), .ifid_ld(ld0), .ifid_flush(fl0),
    .idex_bubble(bb0), .md_busy(busy0), .stall_cycles(sc0), .flush_cycles(fc0));
  hazard_ctrl #(.MD_LATENCY(1), .CNT_W(4)) d1 (.clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt), .id_md_start(id_md_start),
    .id_md_use(id_md_use), .branch_taken(branch_taken), .jump(jump), .pc_ld(pc1), .ifid_ld(ld1),
    .ifid_flush(fl1), .idex_bubble(bb1), .md_busy(busy1), .stall_cycles(sc1), .flush_cycles(fc1));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ctl(input logic p, input logic l, input logic f, input logic b, input string tag);
    #1;
    chk({tag, "_pc_ld"}, 32'(pc0), 32'(p));
    chk({tag, "_ifid_ld"}, 32'(ld0), 32'(l));
    chk({tag, "_flush"}, 32'(fl0), 32'(f));
    chk({tag, "_bubble"}, 32'(bb0), 32'(b));
  endtask
  initial begin
    ctl(0, 0, 0, 1, "in_reset");
    chk("in_reset_busy", 32'(busy0), 0);
    chk("in_reset_sc", 32'(sc0), 0);
    tick;
    rst = 0;
    ctl(1, 1, 0, 0, "idle");
    ex_memread = 1; ex_rt = 8; id_rs = 8;
    ctl(0, 0, 0, 1, "lu_rs");
    tick;
    chk("lu_rs_sc", 32'(sc0), 1);
    ex_rt = 0; id_rs = 0;
    ctl(1, 1, 0, 0, "lu_zero");
    tick;
    chk("lu_zero_sc", 32'(sc0), 1);
    ex_rt = 8; id_rs = 3; id_rt = 8; id_uses_rt = 0;
    ctl(1, 1, 0, 0, "lu_rt_unused");
    id_uses_rt = 1;
    ctl(0, 0, 0, 1, "lu_rt_used");
    tick;
    chk("lu_rt_sc", 32'(sc0), 2);
    ex_memread = 0; branch_taken = 1;
    ctl(1, 1, 1, 0, "branch");
    tick;
    chk("branch_fc", 32'(fc0), 1);
    ex_memread = 1;
    ctl(0, 0, 0, 1, "branch_lu");
    tick;
    chk("branch_lu_sc", 32'(sc0), 3);
    chk("branch_lu_fc", 32'(fc0), 1);
    ex_memread = 0;
    ctl(1, 1, 1, 0, "branch_retry");
    tick;
    chk("branch_retry_fc", 32'(fc0), 2);
    branch_taken = 0; jump = 1;
    ctl(1, 1, 1, 0, "jump");
    tick;
    chk("jump_fc", 32'(fc0), 3);
    jump = 0; id_uses_rt = 0;
    ex_memread = 1; ex_rt = 9; id_rs = 9; id_md_start = 1;
    ctl(0, 0, 0, 1, "md_blocked");
    tick;
    chk("md_blocked_busy", 32'(busy0), 0);
    ex_memread = 0; id_md_use = 1;
    ctl(1, 1, 0, 0, "md_launch");
    tick;
    id_md_start = 0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("md_busy_c%0d", i), 32'(busy0), 1);
      ctl(0, 0, 0, 1, $sformatf("md_stall_c%0d", i));
      tick;
    end
    chk("md_busy_c5", 32'(busy0), 0);
    ctl(1, 1, 0, 0, "md_free_c5");
    chk("md_sc", 32'(sc0), 8);
    id_md_use = 0; id_md_start = 1;
    tick;
    id_md_start = 0;
    chk("pre_rst_busy", 32'(busy0), 1);
    #2 rst = 1;
    #1;
    chk("async_rst_busy", 32'(busy0), 0);
    chk("async_rst_sc", 32'(sc0), 0);
    chk("async_rst_fc", 32'(fc0), 0);
    ctl(0, 0, 0, 1, "async_rst");
    #3 rst = 0;
    ctl(1, 1, 0, 0, "post_rst");
    tick;
    id_md_start = 1; id_md_use = 1;
    #1 chk("l1_launch_pc", 32'(pc1), 1);
    tick;
    chk("l1_busy", 32'(busy1), 1);
    chk("l1_stall_pc", 32'(pc1), 0);
    tick;
    chk("l1_second_busy", 32'(busy1), 0);
    chk("l1_second_pc", 32'(pc1), 1);
    tick;
    id_md_start = 0; id_md_use = 0;
    chk("l1_relaunch_busy", 32'(busy1), 1);
    tick;
    chk("l1_idle_busy", 32'(busy1), 0);
    chk("l1_sc", 32'(sc1), 1);
    rst = 1;
    #2 rst = 0;
    ex_memread = 1; ex_rt = 5; id_rs = 5;
    repeat (20) tick;
    chk("sat_sc_w4", 32'(sc1), 15);
    chk("sat_sc_w16", 32'(sc0), 20);
    ex_memread = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS pipeline.
- Produces load enable and flush for the IF/ID register, PC write enable, and the bubble enable for the ID/EX register.
- Detects load-use hazards and tracks a multi-cycle mul/div unit through a small FSM.
- Orders stall against branch/jump flush.
- Keeps saturating counters of stall and flush cycles.

Parameters:
MD_LATENCY, 4, cycles the mul/div unit stays busy after launch (legal range 1..15)
CNT_W, 16, width of the stall/flush statistics counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
ex_memread  input  1  instruction in EX is a load
ex_rt  input  5  destination rt of the load in EX
id_md_start  input  1  ID instruction is mult/div (launches the unit)
id_md_use  input  1  ID instruction is mfhi/mflo/mult/div (needs the unit idle)
branch_taken  input  1  branch in ID resolved taken
jump  input  1  jump in ID
pc_ld  output  1  PC write enable
ifid_ld  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID flush (zeroes the instruction)
idex_bubble  output  1  ID/EX inserts a nop instead of ID contents
md_busy  output  1  mul/div unit occupied
stall_cycles  output  CNT_W  saturating count of stalled cycles
flush_cycles  output  CNT_W  saturating count of flush cycles

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset rst is asynchronous, active-high.
  - While rst=1: state=RUN, md counter=0, stall_cycles=0, flush_cycles=0, pc_ld=0, ifid_ld=0, ifid_flush=0, idex_bubble=1, md_busy=0.
  - Reset mid-operation abandons any mul/div wait immediately.
- Outputs are Mealy: combinational from the current state and inputs, zero latency. Only the state, md counter and statistics are registered.
- lu_haz = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & (ex_rt==id_rt))).
- md_haz = (state==MD_WAIT) & id_md_use.
- stall = lu_haz | md_haz.
- stall=1: pc_ld=0, ifid_ld=0, idex_bubble=1, ifid_flush=0.
- Stall has priority over flush:
  - A branch/jump in ID during a stall is not acted on; it re-evaluates next cycle.
  - ifid_flush must never be 1 while ifid_ld=0, because the IF/ID register gives flush priority over ld.
- stall=0 and (branch_taken|jump): ifid_flush=1, pc_ld=1, ifid_ld=1, idex_bubble=0.
- Otherwise: pc_ld=1, ifid_ld=1, ifid_flush=0, idex_bubble=0.
- FSM states RUN and MD_WAIT:
  - RUN: if id_md_start & !lu_haz then cnt<=MD_LATENCY-1 and go to MD_WAIT. The launching instruction advances normally.
  - RUN: if id_md_start & lu_haz, no launch; retry next cycle.
  - MD_WAIT: if cnt!=0 then cnt<=cnt-1; if cnt==0 then go to RUN.
  - MD_WAIT, md_busy=1. RUN, md_busy=0.
- An md instruction arriving in ID during the final MD_WAIT cycle (cnt==0) is stalled that cycle and launches in the following RUN cycle. There are no back-to-back launches without a RUN cycle between them.
- MD_LATENCY=1: launch gives exactly one MD_WAIT cycle.
- Statistics:
  - stall_cycles increments on each clock edge where stall=1.
  - flush_cycles increments where ifid_flush=1.
  - Both saturate at all-ones and never wrap.
- ex_rt=0 never causes a hazard ($zero).

Test Plan:
- Reset: assert rst asynchronously mid-cycle with MD_WAIT active -> outputs go to reset values immediately (pc_ld=0, idex_bubble=1, md_busy=0); counters read 0; after release with no hazards, pc_ld=ifid_ld=1.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> pc_ld=0, ifid_ld=0, idex_bubble=1, stall_cycles 0->1. Same case with ex_rt=0 -> no stall. id_rt=8 with id_uses_rt=0 -> no stall.
- Branch flush: branch_taken=1, no hazard -> ifid_flush=1, ifid_ld=1, flush_cycles=1. Branch_taken=1 together with a load-use hazard -> ifid_flush=0, stall=1; next cycle with hazard gone -> flush=1.
- Mul/div, MD_LATENCY=4: id_md_start at cycle 0 -> md_busy=1 for cycles 1..4, 0 at cycle 5. id_md_use held from cycle 1 -> stalled cycles 1..4, advances at cycle 5, stall_cycles=4.
- MD_LATENCY=1: launch, then immediate second mult -> exactly one busy/stall cycle, second launch on the following cycle.
- Saturation: with CNT_W=4, hold lu_haz for 20 cycles -> stall_cycles sticks at 15.
